i2c_target_regs: RTL and testbench

I2C target (responder) for the open-drain split-pin I2C bus driven by the greenhouse controller's initiator. It decodes START/STOP, matches a 7-bit device address, and ACKs. It exposes byte writes and reads to a local register core through a pointer-addressed strobe interface.
Used as an on-chip sensor or peripheral emulator, and as the bus partner in integration benches.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_cond.sv | 62 ++++++
 rtl/i2c_target_regs.sv | 247 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C target register block.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C pad input: 2-flop synchronizer, optional 3-sample glitch
// filter (I2C_TARGET_GLITCH_FILTER_EN), and rise/fall flags of the clean level.
module i2c_line_cond (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;
  logic level;

  // Synchronizer; resets to the idle-bus level so no edge is seen after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q, filt_d;

  // Level follows the input only once three consecutive samples agree.
  always_comb begin
    filt_d = filt_q;
    if (sync2_q == hist_q[0] && sync2_q == hist_q[1]) filt_d = sync2_q;
  end

  // Sample history and filtered level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= filt_d;
    end
  end

  assign level = filt_d;
`else
  assign level = sync2_q;
`endif

  // Previous level for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b1;
    else         prev_q <= level;
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with pointer-addressed register strobes. Optional input glitch
// filtering is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter int unsigned PTR_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_out,
  output logic             sda_out,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             rd_req,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  localparam logic [PTR_W-1:0] PtrOne = 1;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_cond u_scl (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_cond u_sda (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start = scl_lvl & sda_fall;
  assign stop  = scl_lvl & sda_rise;

  i2c_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_q, sda_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             first_q, first_d;   // next write byte is the pointer
  logic             ackph_q, ackph_d;   // ACK bit in progress / read ACK seen
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
  logic             rd_cap_q;
  logic [7:0]       rd_buf_q;
  logic [7:0]       byte_in;

  assign byte_in = {shift_q[6:0], sda_lvl};

  // Protocol FSM: START/STOP override any SCL edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    first_d    = first_q;
    ackph_d    = ackph_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    if (start) begin
      state_d = StAddr;
      cnt_d   = 3'd0;
      sda_d   = I2C_RELEASE;
    end else if (stop) begin
      state_d = StIdle;
      sda_d   = I2C_RELEASE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
                first_d = 1'b1;
                ackph_d = 1'b0;
                state_d = StAddrAck;
                if (byte_in[0]) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = ptr_q;
                end
              end else begin
                busy_d  = 1'b0;
                state_d = StIgnore;
              end
            end
          end
        end
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (!ackph_q) begin
              sda_d   = I2C_ACK;
              ackph_d = 1'b1;
            end else begin
              cnt_d = 3'd0;
              if (state_q == StAddrAck && rw_q) begin
                shift_d = rd_buf_q;
                sda_d   = rd_buf_q[7];
                state_d = StRdByte;
              end else begin
                sda_d   = I2C_RELEASE;
                state_d = StWrByte;
              end
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (first_q) begin
                ptr_d   = byte_in[PTR_W-1:0];
                first_d = 1'b0;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + PtrOne;
              end
              ackph_d = 1'b0;
              state_d = StWrAck;
            end
          end
        end
        StRdByte: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_d   = I2C_RELEASE;
              ackph_d = 1'b0;
              state_d = StRdAck;
            end else begin
              sda_d   = shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise && !ackph_q) begin
            ptr_d = ptr_q + PtrOne;
            if (sda_lvl == I2C_ACK) begin
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q + PtrOne;
              ackph_d   = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && ackph_q) begin
            shift_d = rd_buf_q;
            sda_d   = rd_buf_q[7];
            cnt_d   = 3'd0;
            state_d = StRdByte;
          end
        end
        StIgnore: sda_d = I2C_RELEASE;
        default: ;
      endcase
    end
  end

  // FSM and output registers; reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      sda_q      <= I2C_RELEASE;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ackph_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      ackph_q    <= ackph_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Capture read data exactly once, on the cycle after the request pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cap_q <= 1'b0;
      rd_buf_q <= 8'd0;
    end else begin
      rd_cap_q <= rd_req_q;
      if (rd_cap_q) rd_buf_q <= rd_data;
    end
  end

  assign scl_out  = 1'b1;
  assign sda_out  = sda_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bus-level initiator tasks plus a
// register-space/pointer model of what the target should do.
module tb_i2c_target_regs;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_bus, sda_bus;
  logic       scl_out, sda_out, wr_valid, rd_req, busy;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int n_vec = 0;
  int n_err = 0;

  // Register core attached to the strobe interface.
  logic [7:0]  core_mem [8];
  logic [10:0] wr_q [$];
  logic [2:0]  rd_q [$];
  logic        mon_en = 1'b0;
  int          sda_low_cnt = 0;
  int          busy_cnt = 0;

  // Reference model.
  logic [7:0] model_mem [8];
  logic [2:0] model_ptr;
  logic [7:0] wbuf [$];
  int         glitch_bit = -1;

  assign scl_bus = scl_m & scl_out;
  assign sda_bus = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_target_regs #(
    .DEV_ADDR(7'h48),
    .PTR_W   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_bus),
    .sda_in  (sda_bus),
    .scl_out (scl_out),
    .sda_out (sda_out),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  initial begin
    for (int i = 0; i < 8; i++) begin
      core_mem[i]  = 8'h00;
      model_mem[i] = 8'h00;
    end
    rd_data = 8'h00;
  end

  always @(posedge clk) begin
    if (wr_valid) begin
      core_mem[wr_addr] <= wr_data;
      wr_q.push_back({wr_addr, wr_data});
    end
    if (rd_req) begin
      rd_data <= core_mem[rd_addr];
      rd_q.push_back(rd_addr);
    end
    if (mon_en) begin
      if (!sda_out) sda_low_cnt <= sda_low_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wq(); sda_m = 1'b1;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b1;
    wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      wq(); sda_m = b[i];
      wq(); scl_m = 1'b1;
      wq();
      if (i == glitch_bit) begin
        scl_m = 1'b0;
        @(negedge clk);
        scl_m = 1'b1;
      end
      wq(); scl_m = 1'b0;
    end
    wq(); sda_m = 1'b1;
    wq(); scl_m = 1'b1;
    wq(); ack = sda_bus;
    wq(); scl_m = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wq(); sda_m = 1'b1;
      wq(); scl_m = 1'b1;
      wq(); b[i] = sda_bus;
      wq(); scl_m = 1'b0;
    end
    wq(); sda_m = mack;
    wq(); scl_m = 1'b1;
    wq();
    wq(); scl_m = 1'b0;
  endtask

  // Write transaction: pointer byte then every byte in wbuf.
  task automatic do_write(input logic [7:0] ptr_byte);
    logic        ack;
    logic [2:0]  p;
    logic [10:0] exp_q [$];
    wr_q.delete();
    i2c_start();
    write_byte(8'h90, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(ptr_byte, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_ptr_ack: got %b want 0", ack); end
    p = ptr_byte[2:0];
    foreach (wbuf[k]) begin
      write_byte(wbuf[k], ack);
      n_vec++;
      if (ack !== 1'b0) begin n_err++; $display("FAIL wr_data_ack[%0d]: got %b want 0", k, ack); end
      exp_q.push_back({p, wbuf[k]});
      model_mem[p] = wbuf[k];
      p = p + 3'd1;
    end
    i2c_stop();
    model_ptr = p;
    n_vec++;
    if (wr_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      if (k < wr_q.size()) begin
        n_vec++;
        if (wr_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL wr_strobe[%0d]: got addr %0d data %h want addr %0d data %h",
                   k, wr_q[k][10:8], wr_q[k][7:0], exp_q[k][10:8], exp_q[k][7:0]);
        end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
  endtask

  // Read transaction of n bytes, optionally setting the pointer first.
  task automatic do_read(input int n, input logic set_ptr, input logic [7:0] ptr_byte);
    logic       ack;
    logic [7:0] b;
    logic [2:0] exp_a [$];
    rd_q.delete();
    i2c_start();
    if (set_ptr) begin
      write_byte(8'h90, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_waddr_ack: got %b want 0", ack); end
      write_byte(ptr_byte, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_ptr_ack: got %b want 0", ack); end
      model_ptr = ptr_byte[2:0];
      i2c_rstart();
    end
    write_byte(8'h91, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    for (int k = 0; k < n; k++) begin
      read_byte((k == n - 1) ? 1'b1 : 1'b0, b);
      exp_a.push_back(model_ptr);
      n_vec++;
      if (b !== model_mem[model_ptr]) begin
        n_err++;
        $display("FAIL rd_data[%0d]: got %h want %h", k, b, model_mem[model_ptr]);
      end
      model_ptr = model_ptr + 3'd1;
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
    i2c_stop();
    n_vec++;
    if (rd_q.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL rd_req_count: got %0d want %0d", rd_q.size(), exp_a.size());
    end
    foreach (exp_a[k]) begin
      if (k < rd_q.size()) begin
        n_vec++;
        if (rd_q[k] !== exp_a[k]) begin
          n_err++;
          $display("FAIL rd_addr[%0d]: got %0d want %0d", k, rd_q[k], exp_a[k]);
        end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (sda_out !== 1'b1) begin n_err++; $display("FAIL rst_sda: got %b want 1", sda_out); end
    n_vec++; if (scl_out !== 1'b1) begin n_err++; $display("FAIL rst_scl: got %b want 1", scl_out); end
    n_vec++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL rst_rd_req: got %b want 0", rd_req); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (wr_addr !== 3'd0) begin n_err++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    n_vec++; if (wr_data !== 8'd0) begin n_err++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    n_vec++; if (rd_addr !== 3'd0) begin n_err++; $display("FAIL rst_rd_addr: got %0d want 0", rd_addr); end
    model_ptr = 3'd0;
  endtask

  task automatic test_write();
    wbuf = '{8'hA5, 8'h3C};
    do_write(8'h02);
    // Pointer should now be 4: a bare read must fetch register 4.
    do_read(1, 1'b0, 8'h00);
  endtask

  task automatic test_read();
    wbuf = '{8'h11, 8'h22};
    do_write(8'h05);
    do_read(2, 1'b1, 8'h05);
  endtask

  task automatic test_wrap();
    wbuf = '{8'h77, 8'h80};
    do_write(8'h07);
  endtask

  task automatic test_mismatch();
    logic ack;
    wr_q.delete();
    sda_low_cnt = 0; busy_cnt = 0;
    mon_en = 1'b1;
    i2c_start();
    write_byte(8'h92, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mm_addr_ack: got %b want 1", ack); end
    write_byte(8'hFF, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mm_data_ack: got %b want 1", ack); end
    i2c_stop();
    @(negedge clk);
    mon_en = 1'b0;
    n_vec++; if (sda_low_cnt != 0) begin n_err++; $display("FAIL mm_sda_low: got %0d cycles want 0", sda_low_cnt); end
    n_vec++; if (busy_cnt != 0) begin n_err++; $display("FAIL mm_busy: got %0d cycles want 0", busy_cnt); end
    n_vec++; if (wr_q.size() != 0) begin n_err++; $display("FAIL mm_wr_valid: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    wbuf = '{8'h00};
    do_write(8'h01);
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h01, ack);
    i2c_rstart();
    write_byte(8'h91, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rm_addr_ack: got %b want 0", ack); end
    for (int i = 7; i >= 5; i--) begin
      wq(); sda_m = 1'b1;
      wq(); scl_m = 1'b1;
      wq();
      wq(); scl_m = 1'b0;
    end
    wq(); sda_m = 1'b1;
    wq(); scl_m = 1'b1;
    wq();
    n_vec++; if (sda_out !== 1'b0) begin n_err++; $display("FAIL rm_bit4: got %b want 0", sda_out); end
    rst = 1'b0;
    #1;
    n_vec++; if (sda_out !== 1'b1) begin n_err++; $display("FAIL rm_release: got %b want 1", sda_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wq();
    model_ptr = 3'd0;
    do_read(1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n;
      logic [7:0] p;
      n = $urandom_range(1, 3);
      p = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom_range(0, 255)));
        do_write(p);
      end else begin
        do_read(n, 1'b1, p);
      end
    end
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch();
    wbuf = '{8'h5A};
    glitch_bit = 3;
    do_write(8'h03);
    glitch_bit = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_mismatch();
    test_reset_mid_read();
    test_random();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
